instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 32: byte-address width of PCs and load addresses.
REQ-003 Parameter MEM_WORDS, default 256, power of two: instruction memory depth in words.
REQ-004 Parameter Q_DEPTH, default 4, power of two, at least 2: fetch queue depth.
REQ-005 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port load_en, input, 1: program-load write strobe.
REQ-009 Port load_addr, input, ADDR_W: byte address of the load word.
REQ-010 Port load_data, input, DATA_W: word to write.
REQ-011 Port redirect_valid, input, 1: branch/jump redirect request.
REQ-012 Port redirect_pc, input, ADDR_W: new fetch address.
REQ-013 Port inst_valid, output, 1: queue head holds a valid instruction.
REQ-014 Port inst_ready, input, 1: consumer accepts the head.
REQ-015 Port inst_data, output, DATA_W: head instruction.
REQ-016 Port inst_pc, output, ADDR_W: byte address of the head instruction.

Function
REQ-017 Memory index is addr[log2(MEM_WORDS)+1:2]; bits [1:0] are ignored; upper bits wrap silently.
REQ-018 Load: when load_en=1 and reset=0, load_data is written at load_addr on that edge.
REQ-019 Fetch issue: a read of fetch_pc is issued in a cycle only if load_en=0, redirect_valid=0, and (occupancy + in-flight) < Q_DEPTH; fetch_pc then advances by 4, modulo 2^ADDR_W.
REQ-020 Read latency: one cycle; the word and its PC are pushed at the queue tail on the edge after issue.
REQ-021 Minimum latency: reset release to inst_valid=1 is 2 cycles; an empty queue with inst_ready=1 sustains one instruction per cycle.
REQ-022 Handshake: the head pops on the edge where inst_valid=1 and inst_ready=1; inst_data/inst_pc hold stable while inst_valid=1 and inst_ready=0.
REQ-023 Full: push and pop in the same cycle are allowed; the issue rule guarantees no overflow; no push is ever dropped.
REQ-024 Empty: inst_valid=0; inst_data and inst_pc hold their last values.
REQ-025 Redirect: on an edge with redirect_valid=1, queue entries other than a head popped that same cycle are discarded, the in-flight read is discarded, and fetch_pc becomes redirect_pc.
REQ-026 After a redirect, the first fetch issues the next cycle, so inst_valid=1 with inst_pc=redirect_pc occurs 2 cycles after the redirect edge.
REQ-027 Load during fetch: load_en stalls new issues; queued and in-flight entries are retained; data already queued is not updated by the write.
REQ-028 Load and redirect in the same cycle: both take effect (write performed, flush performed).
REQ-029 A read issued in the same cycle as a write to the same word returns the old contents.

Reset
REQ-030 On reset=1: fetch_pc=RESET_PC, queue empty, in-flight cleared, inst_valid=0, inst_data=0, inst_pc=0.
REQ-031 A reset asserted mid-operation aborts in-flight reads and suppresses any write on that edge.
REQ-032 Memory contents are not cleared by reset.

Verification
REQ-033 Load words 0x11,0x22,0x33 at 0x0,0x4,0x8; release reset; inst_ready=1 -> (inst_pc,inst_data) = (0,0x11),(4,0x22),(8,0x33) on consecutive cycles, first valid 2 cycles after reset release.
REQ-034 inst_ready=0 for 10 cycles -> exactly Q_DEPTH=4 entries accumulate, head stays (0,0x11), fetch_pc stops at 0x10; inst_ready=1 -> PCs 0,4,8,C, then 0x10 with no gap.
REQ-035 Redirect to 0x40 while the queue holds 3 entries -> those entries are never delivered; 2 cycles later inst_pc=0x40.
REQ-036 Load 0xAB at 0x3F2 with MEM_WORDS=256 -> index 0xFC written; a fetch from 0x3F0 returns 0xAB.
REQ-037 Assert reset while inst_valid=1 and load_en=1 -> next cycle inst_valid=0, inst_data=0, inst_pc=0, and the target word is unchanged.
REQ-038 Redirect together with a head pop (inst_valid=1, inst_ready=1) -> the popped head is delivered once; no other old-stream PC appears afterwards.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: single-port word memory, 1-cycle registered read into a Q_DEPTH queue;
// first instruction 2 cycles after reset/redirect; issue throttled by queue + in-flight occupancy under inst_ready backpressure.
module instruction_fetch_unit #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                MEM_WORDS = 256,
    parameter int                Q_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QD = CW'(Q_DEPTH);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [ADDR_W-1:0] fetch_pc;
    logic [IW-1:0]     fetch_idx;
    logic [IW-1:0]     load_idx;

    logic              inflight;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_pc;

    logic [DATA_W-1:0] q_data [Q_DEPTH];
    logic [ADDR_W-1:0] q_pc   [Q_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     occupancy;

    logic [DATA_W-1:0] last_data;
    logic [ADDR_W-1:0] last_pc;

    logic issue;
    logic push;
    logic pop;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{load_addr[ADDR_W-1:IW+2], load_addr[1:0]};

    assign fetch_idx = fetch_pc[IW+1:2];
    assign load_idx  = load_addr[IW+1:2];

    // Counting in-flight reads against capacity means a push always has a free slot.
    always_comb begin
        occupancy = count + {{(CW-1){1'b0}}, inflight};
        issue     = !load_en && !redirect_valid && (occupancy < QD);
        push      = inflight && !redirect_valid;
        pop       = inst_valid && inst_ready;
    end

    always_ff @(posedge clk) begin
        if (load_en && !reset) begin
            mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            rd_data <= mem[fetch_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= rd_data;
            q_pc[wr_ptr]   <= rd_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            inflight  <= 1'b0;
            rd_pc     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
            last_pc   <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end

            inflight <= issue;
            if (issue) begin
                rd_pc <= fetch_pc;
            end

            // A redirect drops everything queued; a head popped on the same edge was already consumed.
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            if (inst_valid) begin
                last_data <= q_data[rd_ptr];
                last_pc   <= q_pc[rd_ptr];
            end
        end
    end

    // Outputs keep showing the most recent head once the queue drains.
    always_comb begin
        inst_valid = (count != '0);
        inst_data  = last_data;
        inst_pc    = last_pc;
        if (inst_valid) begin
            inst_data = q_data[rd_ptr];
            inst_pc   = q_pc[rd_ptr];
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == QD)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: per-cycle vector table plus scoreboarded redirect/load/reset sequences.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] edat;
    } vec_t;

    vec_t        tbl [21];
    logic [31:0] mdl [256];
    logic [63:0] sb_q [$];
    logic [63:0] sb_exp;
    bit          sb_on = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, bit rdy, bit ev, logic [31:0] epc, logic [31:0] edat);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.ev = ev; v.epc = epc; v.edat = edat;
        return v;
    endfunction

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc, mdl[pc[9:2]]};
    endfunction

    // Every accepted instruction must be the next one the model expects.
    always @(negedge clk) begin
        if (sb_on && inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h data %h, expected nothing", inst_pc, inst_data);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_stream", {inst_pc, inst_data}, sb_exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load_en = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        inst_ready = 1'b1;
        for (int k = 0; k < budget && sb_q.size() != 0; k++) cyc();
        inst_ready = 1'b0;
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 32'hC0DE_0000 + 32'(i);
        mdl[0] = 32'h11; mdl[1] = 32'h22; mdl[2] = 32'h33;

        tbl[0]  = mk(0, 1, 0, 32'h0, 32'h0);
        tbl[1]  = mk(0, 1, 0, 32'h0, 32'h0);
        tbl[2]  = mk(0, 1, 1, 32'h0, 32'h11);
        tbl[3]  = mk(0, 1, 1, 32'h4, 32'h22);
        tbl[4]  = mk(0, 1, 1, 32'h8, 32'h33);
        tbl[5]  = mk(1, 1, 1, 32'hC, mdl[3]);
        tbl[6]  = mk(0, 0, 0, 32'h0, 32'h0);
        tbl[7]  = mk(0, 0, 0, 32'h0, 32'h0);
        for (int i = 8; i < 16; i++) tbl[i] = mk(0, 0, 1, 32'h0, 32'h11);
        tbl[16] = mk(0, 1, 1, 32'h0, 32'h11);
        tbl[17] = mk(0, 1, 1, 32'h4, 32'h22);
        tbl[18] = mk(0, 1, 1, 32'h8, 32'h33);
        tbl[19] = mk(0, 1, 1, 32'hC, mdl[3]);
        tbl[20] = mk(0, 1, 1, 32'h10, mdl[4]);

        do_reset();
        chk("reset_valid", 64'(inst_valid), 64'd0);
        for (int i = 0; i < 256; i++) begin
            load_en = 1'b1; load_addr = 32'(i * 4); load_data = mdl[i];
            cyc();
        end
        load_en = 1'b0;
        chk("no_fetch_while_loading", 64'(inst_valid), 64'd0);

        // Memory survives reset; table covers startup latency, streaming, mid-run reset and full queue.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            reset = tbl[i].rst;
            inst_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 64'(inst_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_pc", i), 64'(inst_pc), 64'(tbl[i].epc));
            chk($sformatf("tbl%0d_data", i), 64'(inst_data), 64'(tbl[i].edat));
            @(posedge clk);
            #1;
        end
        sb_on = 1'b1;

        // Redirect with three entries queued and one read in flight.
        do_reset();
        repeat (4) cyc();
        chk("pre_redirect_head", {32'(inst_valid), inst_pc}, {32'd1, 32'h0});
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        chk("redirect_flush_valid", 64'(inst_valid), 64'd0);
        cyc();
        chk("redirect_gap_valid", 64'(inst_valid), 64'd0);
        cyc();
        chk("redirect_first", {32'(inst_valid), inst_pc}, {32'd1, 32'h40});
        sb_q.push_back(ent(32'h40)); sb_q.push_back(ent(32'h44)); sb_q.push_back(ent(32'h48));
        drain(30);

        // Load while entries are queued: queued copies keep the old word.
        do_reset();
        repeat (4) cyc();
        load_en = 1'b1; load_addr = 32'h4; load_data = 32'h55;
        cyc();
        load_en = 1'b0;
        sb_q.push_back(ent(32'h0)); sb_q.push_back(ent(32'h4)); sb_q.push_back(ent(32'h8));
        sb_q.push_back(ent(32'hC)); sb_q.push_back(ent(32'h10));
        mdl[1] = 32'h55;
        drain(30);
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        cyc();
        redirect_valid = 1'b0;
        sb_q.push_back(ent(32'h4));
        drain(30);

        // Load and redirect on the same edge; index wraps from upper address bits.
        load_en = 1'b1; load_addr = 32'h3F2; load_data = 32'hAB;
        redirect_valid = 1'b1; redirect_pc = 32'h3F0;
        cyc();
        load_en = 1'b0; redirect_valid = 1'b0;
        mdl[8'hFC] = 32'hAB;
        sb_q.push_back(ent(32'h3F0)); sb_q.push_back(ent(32'h3F4)); sb_q.push_back(ent(32'h3F8));
        sb_q.push_back(ent(32'h3FC)); sb_q.push_back(ent(32'h400));
        drain(30);
        chk("wrap_data_ab", 64'(mdl[8'hFC]), 64'hAB);
        redirect_valid = 1'b1; redirect_pc = 32'h7F0;
        cyc();
        redirect_valid = 1'b0;
        sb_q.push_back({32'h7F0, 32'hAB});
        drain(30);

        // Reset together with a write: outputs clear and the write is suppressed.
        do_reset();
        repeat (3) cyc();
        chk("pre_reset_valid", 64'(inst_valid), 64'd1);
        reset = 1'b1; load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
        cyc();
        reset = 1'b0; load_en = 1'b0;
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_data", 64'(inst_data), 64'd0);
        chk("rst_pc", 64'(inst_pc), 64'd0);
        sb_q.push_back(ent(32'h0)); sb_q.push_back(ent(32'h4)); sb_q.push_back(ent(32'h8));
        drain(30);

        // Redirect on the same edge as a head pop.
        do_reset();
        sb_q.push_back(ent(32'h0)); sb_q.push_back(ent(32'h4)); sb_q.push_back(ent(32'h8));
        inst_ready = 1'b1;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                cyc();
                if (inst_valid && inst_pc == 32'h8) seen = 1'b1;
            end
            chk("pop_redirect_head_seen", 64'(seen), 64'd1);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        sb_q.push_back(ent(32'h80)); sb_q.push_back(ent(32'h84)); sb_q.push_back(ent(32'h88));
        cyc();
        redirect_valid = 1'b0;
        drain(30);

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
